// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: the canonical NOP,
// fetch FSM state encoding and instruction size.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_holdbuf.sv
// Single-word holding register for an instruction fetched while decode is
// stalled; clear returns it to NOP so a dropped word can never leak out.
module fetch_holdbuf
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] hold_d;
  logic [N-1:0] hold_q;

  // Next buffer value: clear wins over load.
  always_comb begin
    hold_d = hold_q;
    if (clear) begin
      hold_d = N'(NOP_INSTR);
    end else if (load) begin
      hold_d = d;
    end else begin
      hold_d = hold_q;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= N'(NOP_INSTR);
    end else begin
      hold_q <= hold_d;
    end
  end

  assign q = hold_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: owns the PC, runs the
// req/ready handshake to instruction memory, and handles stall and redirect.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic [N-1:0] branch_target,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] ifid_pc,
  output logic [N-1:0] ifid_instr,
  output logic         ifid_valid,
  output logic         fetch_busy
);

  fetch_state_t state_d, state_q;
  logic [N-1:0] pc_d, pc_q;
  logic [N-1:0] redir_d, redir_q;
  logic [N-1:0] ifid_pc_d, ifid_pc_q;
  logic [N-1:0] ifid_instr_d, ifid_instr_q;
  logic         ifid_valid_d, ifid_valid_q;
  logic         req_d, req_q;
  logic         busy_d, busy_q;

  logic         hold_load_s;
  logic         hold_clear_s;
  logic [N-1:0] hold_word_s;
  logic         ready_s;
  logic [N-1:0] target_s;
  logic [N-1:0] pc_next_s;

  fetch_holdbuf #(.N(N)) u_holdbuf (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load_s),
    .clear (hold_clear_s),
    .d     (imem_rdata),
    .q     (hold_word_s)
  );

  // A ready strobe only counts against a request we actually issued.
  assign ready_s   = imem_ready & req_q;
  assign target_s  = branch_target & {{(N-2){1'b1}}, 2'b00};
  assign pc_next_s = pc_q + N'(INSTR_BYTES);

  // Next-state and IF/ID update; priority is flush, then stall, then normal flow.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    hold_load_s  = 1'b0;
    hold_clear_s = 1'b0;

    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = N'(NOP_INSTR);
    end else begin
      ifid_valid_d = ifid_valid_q;
    end

    case (state_q)
      FETCH: begin
        if (flush) begin
          if (ready_s) begin
            pc_d = target_s;
          end else begin
            redir_d = target_s;
            state_d = DRAIN;
          end
        end else if (stall) begin
          if (ready_s) begin
            hold_load_s = 1'b1;
            state_d     = HELD;
          end else begin
            state_d = FETCH;
          end
        end else if (ready_s) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_rdata;
          ifid_valid_d = 1'b1;
          pc_d         = pc_next_s;
        end else begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = N'(NOP_INSTR);
        end
      end
      HELD: begin
        if (flush) begin
          hold_clear_s = 1'b1;
          pc_d         = target_s;
          state_d      = FETCH;
        end else if (stall) begin
          state_d = HELD;
        end else begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = hold_word_s;
          ifid_valid_d = 1'b1;
          pc_d         = pc_next_s;
          hold_clear_s = 1'b1;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        // The abandoned request still has to complete before the redirect.
        if (flush && ready_s) begin
          pc_d    = target_s;
          state_d = FETCH;
        end else if (flush) begin
          redir_d = target_s;
        end else if (ready_s) begin
          pc_d    = redir_q;
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    req_d  = (state_d != HELD);
    busy_d = (state_d != FETCH);
  end

  // Pipeline and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redir_q      <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= N'(NOP_INSTR);
      ifid_valid_q <= 1'b0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_valid = ifid_valid_q;
  assign fetch_busy = busy_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr ^ 32'hCAFE_0000, and all
// expected values below are written out by hand.
module tb_fetch_stage;

  logic        clk;
  logic        rst, rst2;
  logic        stall, flush, stall2, flush2;
  logic [31:0] target, target2;
  logic        ready, ready2;
  logic        req, req2, valid, valid2, busy, busy2;
  logic [31:0] addr, addr2, rdata, rdata2;
  logic [31:0] ipc, ipc2, instr, instr2;

  int n_checks = 0;
  int n_errors = 0;

  assign rdata  = addr  ^ 32'hCAFE_0000;
  assign rdata2 = addr2 ^ 32'hCAFE_0000;

  fetch_stage #(.N(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .branch_target(target),
    .imem_req(req), .imem_addr(addr), .imem_ready(ready), .imem_rdata(rdata),
    .ifid_pc(ipc), .ifid_instr(instr), .ifid_valid(valid), .fetch_busy(busy)
  );

  fetch_stage #(.N(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst2), .stall(stall2), .flush(flush2), .branch_target(target2),
    .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2), .imem_rdata(rdata2),
    .ifid_pc(ipc2), .ifid_instr(instr2), .ifid_valid(valid2), .fetch_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    stall = 1'b0; flush = 1'b0; target = 32'h0; ready = 1'b1;
    stall2 = 1'b0; flush2 = 1'b0; target2 = 32'h0; ready2 = 1'b1;
    step(); step();

    check_eq("rst_req",   {31'd0, req},   32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);
    check_eq("rst_instr", instr,          32'h0000_0013);
    check_eq("rst_pc",    ipc,            32'h0);
    check_eq("rst_busy",  {31'd0, busy},  32'd0);
    rst = 1'b0;

    // Test 1: streaming with ready tied high
    step();
    check_eq("t1_req",   {31'd0, req},   32'd1);
    check_eq("t1_addr0", addr,           32'h0);
    check_eq("t1_valid0",{31'd0, valid}, 32'd0);
    step();
    check_eq("t1_ipc0",  ipc,            32'h0);
    check_eq("t1_ins0",  instr,          32'hCAFE_0000);
    check_eq("t1_val1",  {31'd0, valid}, 32'd1);
    check_eq("t1_addr4", addr,           32'h4);
    step();
    check_eq("t1_ipc4",  ipc,            32'h4);
    check_eq("t1_addr8", addr,           32'h8);

    // Test 2: two memory wait cycles at 0x8
    ready = 1'b0;
    step();
    check_eq("t2_addr_a",  addr,           32'h8);
    check_eq("t2_bub_a",   {31'd0, valid}, 32'd0);
    check_eq("t2_nop_a",   instr,          32'h0000_0013);
    step();
    check_eq("t2_addr_b",  addr,           32'h8);
    check_eq("t2_bub_b",   {31'd0, valid}, 32'd0);
    ready = 1'b1;
    step();
    check_eq("t2_ipc8",    ipc,            32'h8);
    check_eq("t2_ins8",    instr,          32'hCAFE_0008);
    check_eq("t2_addrC",   addr,           32'hC);

    // Test 3: three stall cycles while 0xC is returned
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t3_req_held", {31'd0, req},  32'd0);
      check_eq("t3_busy",     {31'd0, busy}, 32'd1);
      check_eq("t3_ipc_frz",  ipc,           32'h8);
    end
    stall = 1'b0;
    step();
    check_eq("t3_ipcC",  ipc,           32'hC);
    check_eq("t3_insC",  instr,         32'hCAFE_000C);
    check_eq("t3_addr10",addr,          32'h10);
    check_eq("t3_req",   {31'd0, req},  32'd1);
    check_eq("t3_nbusy", {31'd0, busy}, 32'd0);

    // Test 4: flush while the 0x10 request is outstanding
    ready = 1'b0; flush = 1'b1; target = 32'h100;
    step();
    flush = 1'b0;
    check_eq("t4_busy",   {31'd0, busy},  32'd1);
    check_eq("t4_stale",  addr,           32'h10);
    check_eq("t4_req",    {31'd0, req},   32'd1);
    check_eq("t4_val_a",  {31'd0, valid}, 32'd0);
    check_eq("t4_nop",    instr,          32'h0000_0013);
    step();
    check_eq("t4_stale2", addr,           32'h10);
    check_eq("t4_val_b",  {31'd0, valid}, 32'd0);
    ready = 1'b1;
    step();
    check_eq("t4_redir",  addr,           32'h100);
    check_eq("t4_val_c",  {31'd0, valid}, 32'd0);
    check_eq("t4_nbusy",  {31'd0, busy},  32'd0);
    step();
    check_eq("t4_ipc100", ipc,            32'h100);
    check_eq("t4_ins100", instr,          32'hCAFE_0100);

    // Test 5: flush and stall together while HELD
    stall = 1'b1;
    step();
    check_eq("t5_held", {31'd0, req}, 32'd0);
    flush = 1'b1; target = 32'h203;
    step();
    flush = 1'b0; stall = 1'b0;
    check_eq("t5_addr200", addr,           32'h200);
    check_eq("t5_val",     {31'd0, valid}, 32'd0);
    check_eq("t5_req",     {31'd0, req},   32'd1);
    step();
    check_eq("t5_ipc200",  ipc,            32'h200);
    check_eq("t5_ins200",  instr,          32'hCAFE_0200);

    // Flush coinciding with a ready response in FETCH
    flush = 1'b1; target = 32'h40;
    step();
    flush = 1'b0;
    check_eq("t5b_addr40", addr,           32'h40);
    check_eq("t5b_val",    {31'd0, valid}, 32'd0);
    check_eq("t5b_busy",   {31'd0, busy},  32'd0);

    // Test 6: PC wrap and asynchronous reset during DRAIN
    rst2 = 1'b0;
    step();
    check_eq("t6_addr_top", addr2,  32'hFFFF_FFFC);
    step();
    check_eq("t6_ipc_top",  ipc2,   32'hFFFF_FFFC);
    check_eq("t6_wrap",     addr2,  32'h0);
    step();
    check_eq("t6_ipc0",     ipc2,   32'h0);
    check_eq("t6_addr4",    addr2,  32'h4);
    ready2 = 1'b0; flush2 = 1'b1; target2 = 32'h80;
    step();
    flush2 = 1'b0;
    check_eq("t6_drain",    {31'd0, busy2}, 32'd1);
    #2;
    rst2 = 1'b1;
    #1;
    check_eq("t6_rst_req",  {31'd0, req2},   32'd0);
    check_eq("t6_rst_pc",   addr2,           32'hFFFF_FFFC);
    check_eq("t6_rst_busy", {31'd0, busy2},  32'd0);
    check_eq("t6_rst_val",  {31'd0, valid2}, 32'd0);
    step();
    rst2 = 1'b0; ready2 = 1'b1;
    step();
    check_eq("t6_restart",  addr2,  32'hFFFF_FFFC);
    check_eq("t6_rereq",    {31'd0, req2}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
